result_reducer: RTL and testbench
=================================

RESULT_REDUCER -- requirements
Module: result_reducer

Interface
REQ-001 Parameter NUM_CELLS, default 8, meaning the number of cell results folded per operation; the legal range is 1..255.
REQ-002 The design SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begins an operation; sampled only in IDLE.
REQ-006 selector  in  8  operation code, captured on start: 0 update, 1 lookUpScan, 2 lookUpFinalizer, 3 encode, 4 delete, 5 congrueUp, 6 congrueDown, 7 markAvailableCell.
REQ-007 in_valid  in  1  a cell result is present.
REQ-008 in_ready  out  1  the block accepts a cell result.
REQ-009 in_value / in_context  in  8 each  value and context of the cell result.
REQ-010 in_bool  in  1  hit flag of the cell result.
REQ-011 out_valid  out  1  the reduced result is available.
REQ-012 out_ready  in  1  the consumer accepts the reduced result.
REQ-013 out_value / out_context  out  8 each  reduced value and context.
REQ-014 out_bool  out  1  OR of all accepted in_bool.
REQ-015 busy  out  1  high in ACCUM and DONE.

Function
REQ-016 The block SHALL use three states: IDLE, ACCUM, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0, busy=0; start=1 SHALL latch selector, clear the accumulator (value 0, context 0, bool 0) and beat count to 0, and go to ACCUM on the next edge.
REQ-018 ACCUM: in_ready SHALL be 1 combinationally; a beat is accepted when in_valid && in_ready.
REQ-019 Each accepted beat SHALL update the accumulator to combine(acc, in) and increment the beat count.
REQ-020 In combine, the accumulator is the left operand and the incoming beat is the right operand; result bool = left bool OR right bool.
REQ-021 Take-left rule when both bools=1 and selector=1: keep left iff left context > right context.
REQ-022 Take-left rule when both bools=1 and selector=5: keep left iff left context < right context.
REQ-023 Take-left rule in all other cases (any other selector, including values >7, or either bool=0): keep left iff left bool=1.
REQ-024 Value and context SHALL come together from the chosen side; context ties under selector 1/5 choose right (incoming).
REQ-025 When both bools are 0, the incoming value and context SHALL replace the accumulator.
REQ-026 The accept of beat number NUM_CELLS SHALL move the state to DONE; out_valid rises on the cycle after that accept (1-cycle latency).
REQ-027 The beat counter SHALL be clog2(NUM_CELLS+1) bits wide and never wrap within an operation.
REQ-028 DONE: out_valid=1, in_ready=0; out_value, out_context and out_bool SHALL be held stable until out_valid && out_ready, then the state goes to IDLE.
REQ-029 start SHALL be ignored outside IDLE, including in the same cycle as the DONE handshake; a new operation needs start in IDLE.
REQ-030 in_valid outside ACCUM SHALL be ignored, with no state change.
REQ-031 Gaps (in_valid=0) during ACCUM SHALL stall with no accumulator change.
REQ-032 Outputs SHALL be registered, except in_ready, which is decoded from the state only.

Reset
REQ-033 On reset=1 at a clock edge: state IDLE, accumulator 0/0/0, count 0, selector register 0, out_valid=0, busy=0, in_ready=0; out_value=0, out_context=0, out_bool=0.
REQ-034 Reset mid-ACCUM or in DONE SHALL discard the partial or pending result with no out_valid pulse; reset has priority over start and handshakes in the same cycle.

Verification
REQ-035 NUM_CELLS=4, selector=1, beats (v,c,b) = (10,3,1),(20,7,1),(30,7,1),(40,2,0) -> out 30/7/1 (tie picks right), out_valid one cycle after the 4th accept.
REQ-036 NUM_CELLS=4, selector=5, beats (10,9,1),(20,4,1),(30,6,1),(40,1,0) -> out 20/4/1.
REQ-037 NUM_CELLS=3, selector=3, beats (5,1,0),(6,2,1),(7,3,1) -> out 6/2/1 (first hit kept); all bools 0 with last beat (9,9,0) -> out 9/9/0.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE with start pulsed -> outputs stable, no restart; out_ready=1 -> IDLE next cycle, busy=0.
REQ-039 Reset asserted after 2 of 4 beats -> IDLE next cycle, no out_valid; a new start plus 4 beats yields a correct result unaffected by the discarded beats.
REQ-040 in_valid toggling randomly against a reference fold model over 1000 operations, all selectors 0..255 -> every result matches, exactly one out_valid per start.

Source files
------------

// File: rtl/result_reducer_if.sv
// -----------------------------------------------------------------------------
// result_reducer_if
//
// Bundles the two handshake channels of result_reducer:
//   in_*  : cell-result stream (in_valid/in_ready plus value, context, hit flag)
//   out_* : reduced-result stream (out_valid/out_ready plus value, context, flag)
//
// Modports:
//   slave  : the reducer side (consumes in_*, produces out_*)
//   master : the environment side (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface result_reducer_if;

    // Cell-result channel
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic [7:0] in_context;
    logic       in_bool;

    // Reduced-result channel
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic [7:0] out_context;
    logic       out_bool;

    modport slave (
        input  in_valid,
        input  in_value,
        input  in_context,
        input  in_bool,
        output in_ready,
        output out_valid,
        output out_value,
        output out_context,
        output out_bool,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_value,
        output in_context,
        output in_bool,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_context,
        input  out_bool,
        output out_ready
    );

endinterface

// File: rtl/result_reducer.sv
// -----------------------------------------------------------------------------
// result_reducer
//
// Folds NUM_CELLS cell results into one reduced result. An operation is
// launched by start in IDLE, which latches the operation selector and clears
// the accumulator. Each accepted cell result is combined into the accumulator;
// the accept of the last beat moves to DONE, where the result is presented
// until the consumer takes it.
//
// Combine rule (accumulator = left, incoming beat = right):
//   both hit, selector 1 : keep left iff left context > right context
//   both hit, selector 5 : keep left iff left context < right context
//   otherwise            : keep left iff left hit
//   value and context always travel together; hit flag is the OR of both.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   start    : begin an operation (sampled only in IDLE)
//   selector : operation code, captured on start
//   busy     : high while accumulating or holding a result
//   bus      : result_reducer_if.slave (cell-result in, reduced-result out)
// -----------------------------------------------------------------------------
module result_reducer #(
    parameter int unsigned NUM_CELLS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        selector,
    output logic              busy,
    result_reducer_if.slave   bus
);

    // Wide enough to hold NUM_CELLS itself, so the count never wraps.
    localparam int unsigned CntW = $clog2(NUM_CELLS + 1);

    localparam logic [CntW-1:0] LastBeat = CntW'(NUM_CELLS - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [7:0] SelLookUpScan = 8'd1;
    localparam logic [7:0] SelCongrueUp  = 8'd5;

    logic [1:0]      state_q,       state_d;
    logic [7:0]      sel_q,         sel_d;
    logic [7:0]      acc_value_q,   acc_value_d;
    logic [7:0]      acc_context_q, acc_context_d;
    logic            acc_bool_q,    acc_bool_d;
    logic [CntW-1:0] cnt_q,         cnt_d;
    logic            out_valid_q,   out_valid_d;
    logic            busy_q,        busy_d;

    logic accept;
    logic both_hit;
    logic take_left;

    // in_ready is the only output decoded straight from state.
    assign bus.in_ready = (state_q == StAccum);
    assign accept       = bus.in_valid && (state_q == StAccum);

    // ------------------------------------------------------------------
    // Combine decision: does the accumulator (left) survive this beat?
    // ------------------------------------------------------------------
    assign both_hit = acc_bool_q && bus.in_bool;

    always_comb begin
        take_left = acc_bool_q;
        if (both_hit) begin
            if (sel_q == SelLookUpScan) begin
                take_left = (acc_context_q > bus.in_context);
            end else if (sel_q == SelCongrueUp) begin
                take_left = (acc_context_q < bus.in_context);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        acc_value_d   = acc_value_q;
        acc_context_d = acc_context_q;
        acc_bool_d    = acc_bool_q;
        cnt_d         = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    sel_d         = selector;
                    acc_value_d   = 8'd0;
                    acc_context_d = 8'd0;
                    acc_bool_d    = 1'b0;
                    cnt_d         = '0;
                    state_d       = StAccum;
                end
            end

            StAccum: begin
                if (accept) begin
                    if (!take_left) begin
                        acc_value_d   = bus.in_value;
                        acc_context_d = bus.in_context;
                    end
                    acc_bool_d = acc_bool_q || bus.in_bool;
                    cnt_d      = cnt_q + CntOne;
                    if (cnt_q == LastBeat) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                // start is deliberately not looked at here, even on the
                // handshake cycle: a new operation needs start in IDLE.
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered status outputs follow the next state so they line up
        // with state_q after the edge.
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d != StIdle);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sel_q         <= 8'd0;
            acc_value_q   <= 8'd0;
            acc_context_q <= 8'd0;
            acc_bool_q    <= 1'b0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            acc_value_q   <= acc_value_d;
            acc_context_q <= acc_context_d;
            acc_bool_q    <= acc_bool_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    // The accumulator is frozen in DONE, so it doubles as the output register.
    assign bus.out_valid   = out_valid_q;
    assign bus.out_value   = acc_value_q;
    assign bus.out_context = acc_context_q;
    assign bus.out_bool    = acc_bool_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_result_reducer.sv
// -----------------------------------------------------------------------------
// tb_result_reducer
//
// Bench for result_reducer. A NUM_CELLS=4 instance runs a vector table,
// backpressure/reset corner sequences and a long random run; expected results
// are queued at start and compared when the output handshake occurs. A
// NUM_CELLS=3 instance runs the short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_result_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, start3;
    logic [7:0] sel4, sel3;
    logic       busy4, busy3;

    result_reducer_if if4 ();
    result_reducer_if if3 ();

    result_reducer #(.NUM_CELLS(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start4),
        .selector (sel4),
        .busy     (busy4),
        .bus      (if4)
    );

    result_reducer #(.NUM_CELLS(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start3),
        .selector (sel3),
        .busy     (busy3),
        .bus      (if3)
    );

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] c;
        logic       b;
    } res_t;

    typedef struct {
        logic [7:0] sel;
        res_t       beats [4];
        res_t       exp;
    } vec_t;

    int   checks  = 0;
    int   errors  = 0;
    int   n_start = 0;
    int   n_out   = 0;
    res_t exp_q [$];
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t mk(input int v, input int c, input int b);
        return {8'(v), 8'(c), 1'(b)};
    endfunction

    // Reference fold step: l is the accumulator, r the incoming beat.
    function automatic res_t combine(input logic [7:0] sel, input res_t l, input res_t r);
        logic keep_l;
        res_t o;
        keep_l = l.b;
        if (l.b && r.b && sel == 8'd1) keep_l = (l.c > r.c);
        else if (l.b && r.b && sel == 8'd5) keep_l = (l.c < r.c);
        o   = keep_l ? l : r;
        o.b = l.b | r.b;
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every output handshake of the 4-cell instance pops one.
    always @(negedge clk) begin
        if (!reset && if4.out_valid && if4.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(exp_q.size()), 1);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_value",   32'(if4.out_value),   32'(e.v));
                chk("out_context", 32'(if4.out_context), 32'(e.c));
                chk("out_bool",    32'(if4.out_bool),    32'(e.b));
            end
        end
    end

    // One full operation on the 4-cell instance. bp = cycles of out_ready=0
    // in DONE, during which start and in_valid are asserted to prove they are
    // ignored.
    task automatic run_op4(input logic [7:0] sel, input res_t beats [4], input res_t exp,
                           input bit gaps, input int bp);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        exp_q.push_back(exp);
        n_start++;
        start4 = 1'b1;
        sel4   = sel;
        tick();
        start4 = 1'b0;
        sel4   = 8'($urandom);
        chk("busy_in_accum", 32'(busy4), 1);
        chk("in_ready_in_accum", 32'(if4.in_ready), 1);
        while (idx < 4 && guard < 200) begin
            if4.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (if4.in_valid) {if4.in_value, if4.in_context, if4.in_bool} = beats[idx];
            else {if4.in_value, if4.in_context, if4.in_bool} = 17'($urandom);
            if (if4.in_valid && if4.in_ready) begin
                idx++;
                if (idx == 4) chk("out_valid_early", 32'(if4.out_valid), 0);
            end
            tick();
            guard++;
        end
        chk("beats_accepted", 32'(idx), 4);
        chk("out_valid_latency", 32'(if4.out_valid), 1);
        chk("in_ready_in_done", 32'(if4.in_ready), 0);
        for (int k = 0; k < bp; k++) begin
            start4       = 1'b1;
            if4.in_valid = 1'b1;
            {if4.in_value, if4.in_context, if4.in_bool} = 17'($urandom);
            tick();
            chk("bp_out_valid", 32'(if4.out_valid),   1);
            chk("bp_value",     32'(if4.out_value),   32'(exp.v));
            chk("bp_context",   32'(if4.out_context), 32'(exp.c));
            chk("bp_bool",      32'(if4.out_bool),    32'(exp.b));
        end
        if4.out_ready = 1'b1;
        start4        = (bp > 0);
        tick();
        if4.out_ready = 1'b0;
        start4        = 1'b0;
        if4.in_valid  = 1'b0;
        chk("busy_after_handshake", 32'(busy4), 0);
        chk("out_valid_after_handshake", 32'(if4.out_valid), 0);
    endtask

    task automatic run_op3(input logic [7:0] sel, input res_t beats [3], input res_t exp);
        start3 = 1'b1;
        sel3   = sel;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if3.in_valid = 1'b1;
            {if3.in_value, if3.in_context, if3.in_bool} = beats[k];
            tick();
        end
        if3.in_valid = 1'b0;
        chk("n3_out_valid",   32'(if3.out_valid),   1);
        chk("n3_out_value",   32'(if3.out_value),   32'(exp.v));
        chk("n3_out_context", 32'(if3.out_context), 32'(exp.c));
        chk("n3_out_bool",    32'(if3.out_bool),    32'(exp.b));
        if3.out_ready = 1'b1;
        tick();
        if3.out_ready = 1'b0;
        chk("n3_idle_after_handshake", 32'(busy3), 0);
    endtask

    initial begin
        res_t acc;
        res_t rb [4];
        res_t b3 [3];
        logic [7:0] rsel;

        reset  = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
        sel4   = 8'd0;
        sel3   = 8'd0;
        if4.in_valid = 1'b0; if4.in_value = 8'd0; if4.in_context = 8'd0; if4.in_bool = 1'b0;
        if4.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.in_value = 8'd0; if3.in_context = 8'd0; if3.in_bool = 1'b0;
        if3.out_ready = 1'b0;

        // Vector table (accumulator starts at 0/0/0 each operation).
        tbl[0].sel = 8'd1;
        tbl[0].beats = '{mk(10, 3, 1), mk(20, 7, 1), mk(30, 7, 1), mk(40, 2, 0)};
        tbl[0].exp = mk(30, 7, 1);
        tbl[1].sel = 8'd5;
        tbl[1].beats = '{mk(10, 9, 1), mk(20, 4, 1), mk(30, 6, 1), mk(40, 1, 0)};
        tbl[1].exp = mk(20, 4, 1);
        tbl[2].sel = 8'd0;
        tbl[2].beats = '{mk(1, 1, 0), mk(2, 2, 1), mk(3, 3, 1), mk(4, 4, 0)};
        tbl[2].exp = mk(2, 2, 1);
        tbl[3].sel = 8'd1;
        tbl[3].beats = '{mk(11, 12, 0), mk(13, 14, 0), mk(15, 16, 0), mk(17, 18, 0)};
        tbl[3].exp = mk(17, 18, 0);
        tbl[4].sel = 8'd9;
        tbl[4].beats = '{mk(50, 200, 0), mk(60, 100, 1), mk(70, 250, 1), mk(80, 5, 1)};
        tbl[4].exp = mk(60, 100, 1);
        tbl[5].sel = 8'd5;
        tbl[5].beats = '{mk(1, 5, 1), mk(2, 5, 1), mk(3, 5, 1), mk(4, 9, 1)};
        tbl[5].exp = mk(3, 5, 1);
        tbl[6].sel = 8'd1;
        tbl[6].beats = '{mk(1, 0, 1), mk(2, 255, 1), mk(3, 254, 1), mk(4, 0, 0)};
        tbl[6].exp = mk(2, 255, 1);
        tbl[7].sel = 8'd255;
        tbl[7].beats = '{mk(9, 1, 0), mk(8, 2, 0), mk(7, 3, 1), mk(6, 4, 0)};
        tbl[7].exp = mk(7, 3, 1);

        // Reset state.
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready",    32'(if4.in_ready),    0);
        chk("rst_out_valid",   32'(if4.out_valid),   0);
        chk("rst_busy",        32'(busy4),           0);
        chk("rst_out_value",   32'(if4.out_value),   0);
        chk("rst_out_context", 32'(if4.out_context), 0);
        chk("rst_out_bool",    32'(if4.out_bool),    0);

        // Table pass; entry 1 also holds 5 cycles of backpressure with start.
        for (int i = 0; i < 8; i++) begin
            run_op4(tbl[i].sel, tbl[i].beats, tbl[i].exp, (i >= 4), (i == 1) ? 5 : (i % 3));
        end

        // in_valid in IDLE must not disturb the held result.
        if4.in_valid = 1'b1;
        {if4.in_value, if4.in_context, if4.in_bool} = mk(99, 99, 1);
        repeat (3) tick();
        if4.in_valid = 1'b0;
        chk("idle_ignore_busy",  32'(busy4),         0);
        chk("idle_ignore_value", 32'(if4.out_value), 32'(tbl[7].exp.v));
        chk("idle_ignore_ctx",   32'(if4.out_context), 32'(tbl[7].exp.c));

        // Reset after 2 of 4 beats, colliding with start/in_valid/out_ready.
        start4 = 1'b1;
        sel4   = 8'd1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if4.in_valid = 1'b1;
            {if4.in_value, if4.in_context, if4.in_bool} = mk(200 + k, 250, 1);
            tick();
        end
        reset         = 1'b1;
        start4        = 1'b1;
        if4.out_ready = 1'b1;
        tick();
        reset         = 1'b0;
        start4        = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b0;
        chk("mid_rst_busy",      32'(busy4),           0);
        chk("mid_rst_in_ready",  32'(if4.in_ready),    0);
        chk("mid_rst_out_value", 32'(if4.out_value),   0);
        chk("mid_rst_out_ctx",   32'(if4.out_context), 0);
        chk("mid_rst_out_bool",  32'(if4.out_bool),    0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_out_valid", 32'(if4.out_valid), 0);
            tick();
        end
        run_op4(tbl[0].sel, tbl[0].beats, tbl[0].exp, 1'b0, 0);

        // NUM_CELLS=3 sequences.
        b3 = '{mk(5, 1, 0), mk(6, 2, 1), mk(7, 3, 1)};
        run_op3(8'd3, b3, mk(6, 2, 1));
        b3 = '{mk(1, 1, 0), mk(2, 2, 0), mk(9, 9, 0)};
        run_op3(8'd3, b3, mk(9, 9, 0));

        // Random operations against the reference fold.
        for (int op = 0; op < 1000; op++) begin
            rsel = 8'($urandom_range(0, 255));
            if (op % 4 == 0) rsel = 8'(1 + 4 * ($urandom_range(0, 1)));
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                rb[k] = mk($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 1));
                acc   = combine(rsel, acc, rb[k]);
            end
            run_op4(rsel, rb, acc, 1'b1, $urandom_range(0, 2));
        end

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("one_out_per_start",  32'(n_out), 32'(n_start));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
